// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS MEM stage: fixed-latency load/store from a word array,
// with a pipeline stall request, error flagging and saturating debug counters.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2,
    parameter logic [15:0] CNT_MAX    = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_ack,
    output logic        mem_err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] idx;
        logic [31:0]           data;
        logic                  wr;
        logic                  err;   // any error, including ren&wen together
        logic                  bad;   // address itself unusable: array untouched
    } req_t;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    logic [31:0] din_q, din_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [15:0] rd_q, rd_d;
    logic [15:0] wr_q, wr_d;

    logic [31:0] mem_q [2**ADDR_WIDTH];

    logic req_present, addr_bad, fire, do_write, do_read;

    assign req_present = mem_ren | mem_wen;
    assign addr_bad    = (mem_addr[1:0] != 2'b00) || ((mem_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign fire        = (state_q == BUSY) && (cnt_q == 4'd0);
    assign do_write    = fire && req_q.wr && !req_q.bad;
    assign do_read     = fire && !req_q.wr && !req_q.err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        din_d   = din_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rd_d    = rd_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (req_present) begin
                    req_d.idx  = mem_addr[ADDR_WIDTH+1:2];
                    req_d.data = mem_dout;
                    req_d.wr   = mem_wen;
                    req_d.bad  = addr_bad;
                    req_d.err  = addr_bad | (mem_ren & mem_wen);
                    cnt_d      = 4'(LATENCY - 1);
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ack_d   = 1'b1;
                    err_d   = req_q.err;
                    state_d = RESP;
                    if (req_q.err)
                        din_d = 32'd0;
                    else if (do_read)
                        din_d = mem_q[req_q.idx];
                    if (do_read && rd_q != CNT_MAX)
                        rd_d = rd_q + 16'd1;
                    if (do_write && wr_q != CNT_MAX)
                        wr_d = wr_q + 16'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            din_q   <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 16'd0;
            wr_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            din_q   <= din_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Array is deliberately not reset; a reset mid-access leaves state IDLE so no write fires.
    always_ff @(posedge clk) begin
        if (do_write)
            mem_q[req_q.idx] <= req_q.data;
    end

    assign mem_stall = ((state_q == IDLE) && req_present) || (state_q == BUSY);
    assign mem_din   = din_q;
    assign mem_ack   = ack_q;
    assign mem_err   = err_q;
    assign rd_count  = rd_q;
    assign wr_count  = wr_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder; a second instance with a low counter
// ceiling shares the stimulus so saturation is reachable in a short run.
module tb_dmem_responder;
    localparam int          AW   = 10;
    localparam int          LAT  = 2;
    localparam logic [15:0] SMAX = 16'd3;

    logic        clk = 1'b0, rst_n = 1'b1, ren = 1'b0, wen = 1'b0;
    logic [31:0] addr = 32'd0, dout = 32'd0;
    logic [31:0] din, din2;
    logic        stall, ack, err, stall2, ack2, err2;
    logic [15:0] rdc, wrc, rdc2, wrc2;

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .mem_ren(ren), .mem_wen(wen), .mem_addr(addr),
        .mem_dout(dout), .mem_din(din), .mem_stall(stall), .mem_ack(ack),
        .mem_err(err), .rd_count(rdc), .wr_count(wrc));

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .CNT_MAX(SMAX)) dut_sat (
        .clk(clk), .rst_n(rst_n), .mem_ren(ren), .mem_wen(wen), .mem_addr(addr),
        .mem_dout(dout), .mem_din(din2), .mem_stall(stall2), .mem_ack(ack2),
        .mem_err(err2), .rd_count(rdc2), .wr_count(wrc2));

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] din;
        bit          din_ok;
        int          wr;
        int          rd;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0, checks = 0;
    logic [31:0] mdl[int];
    int          m_wr = 0, m_rd = 0;
    logic [31:0] m_din = 32'd0;
    bit          m_din_ok = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Issue one access, update the reference model, and check the stall/ack timeline.
    task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        bit   bad;
        int   idx;
        @(negedge clk);
        ren = r; wen = w; addr = a; dout = d;
        bad   = (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
        idx   = int'(a[AW+1:2]);
        e.err = bad || (r && w);
        if (w && !bad) begin
            mdl[idx] = d;
            m_wr = sat(m_wr + 1, 65535);
        end
        if (e.err) begin
            m_din = 32'd0;
            m_din_ok = 1'b1;
        end else if (!w) begin
            m_din_ok = mdl.exists(idx);
            if (m_din_ok) m_din = mdl[idx];
            m_rd = sat(m_rd + 1, 65535);
        end
        e.din = m_din; e.din_ok = m_din_ok; e.wr = m_wr; e.rd = m_rd;
        sb.push_back(e);
        #1 chk("stall_req", 32'(stall), 32'd1);
        repeat (LAT) begin
            @(negedge clk);
            chk("stall_busy", 32'(stall), 32'd1);
            chk("ack_early", 32'(ack), 32'd0);
        end
        @(negedge clk);
        chk("stall_resp", 32'(stall), 32'd0);
        chk("ack_resp", 32'(ack), 32'd1);
        ren = 1'b0; wen = 1'b0;
    endtask

    // Monitor: every acknowledge is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ack === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("err", 32'(err), 32'(e.err));
                chk("wr_count", 32'(wrc), 32'(e.wr));
                chk("rd_count", 32'(rdc), 32'(e.rd));
                chk("sat_ack", 32'(ack2), 32'd1);
                chk("sat_err", 32'(err2), 32'(e.err));
                chk("sat_stall", 32'(stall2), 32'd0);
                chk("sat_wr_count", 32'(wrc2), 32'(sat(e.wr, int'(SMAX))));
                chk("sat_rd_count", 32'(rdc2), 32'(sat(e.rd, int'(SMAX))));
                if (e.din_ok) begin
                    chk("din", din, e.din);
                    chk("sat_din", din2, e.din);
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_din"}, din, 32'd0);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_rd"}, 32'(rdc), 32'd0);
        chk({tag, "_wr"}, 32'(wrc), 32'd0);
        chk({tag, "_sat_wr"}, 32'(wrc2), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        // Asynchronous reset mid-cycle with random non-request inputs.
        #2;
        addr = $urandom; dout = $urandom;
        rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h10, 32'h0);
        access(1'b1, 1'b0, 32'h13, 32'h0);          // misaligned
        access(1'b1, 1'b0, 32'h10, 32'h0);
        access(1'b0, 1'b1, 32'h0, 32'hCAFEF00D);
        access(1'b0, 1'b1, 32'h1000, 32'h12345678); // out of range
        access(1'b1, 1'b0, 32'h0, 32'h0);
        access(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);   // both asserted: error, still stored
        access(1'b1, 1'b0, 32'h20, 32'h0);
        access(1'b0, 1'b1, 32'hFFC, 32'h0BADF00D);  // last word of the array
        access(1'b1, 1'b0, 32'hFFC, 32'h0);

        // Reset during a store's BUSY phase: store discarded, counters cleared.
        @(negedge clk);
        ren = 1'b0; wen = 1'b1; addr = 32'h20; dout = 32'h11111111;
        @(negedge clk);
        #2;
        ren = 1'b0; wen = 1'b0;
        rst_n = 1'b0;
        #1 chk_reset_outputs("rst_busy");
        m_wr = 0; m_rd = 0; m_din = 32'd0; m_din_ok = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b1, 1'b0, 32'h20, 32'h0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: a = 32'($urandom_range(0, 15)) << 2;
                3:       a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
                4:       a = 32'h1000 | (32'($urandom_range(0, 1023)) << 2);
                default: a = 32'($urandom_range(0, 1023)) << 2;
            endcase
            op = $urandom_range(0, 4);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            access(op <= 1 || op == 4, op >= 2, a, $urandom);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the 5-stage MIPS pipeline: the slave end of the datapath's MEM-stage port (`mem_ren`/`mem_wen`/`mem_addr`/`mem_dout` in, `mem_din` out). It serves each load or store from an internal word array with a fixed, parameterized access latency. While an access is in flight it asserts `mem_stall`, which the pipeline control uses to freeze every stage. It also flags misaligned and out-of-range accesses and keeps saturating access counters for debug.

## Interface
- `ADDR_WIDTH`, default 10: word-address width; the array holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 2: wait cycles per access; legal range 1..15.
- `clk` in 1: clock; everything is on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_ren` in 1: load request from the MEM stage.
- `mem_wen` in 1: store request from the MEM stage.
- `mem_addr` in 32: byte address (ALU result).
- `mem_dout` in 32: store data from the datapath.
- `mem_din` out 32: load data to the datapath.
- `mem_stall` out 1: pipeline-freeze request.
- `mem_ack` out 1: one-cycle completion pulse.
- `mem_err` out 1: error flag for the access being acknowledged.
- `rd_count` out 16: completed loads, saturating.
- `wr_count` out 16: completed stores, saturating.

## Operation
- **States:** IDLE, BUSY, RESP. Internal registers: 4-bit down-counter `cnt`, and a captured copy of the request (address, data, write flag, error flag).
- **IDLE**
  - A request is present when `mem_ren | mem_wen`.
  - With a request present, the next edge captures it, loads `cnt = LATENCY-1` and goes to BUSY.
  - With no request, stay in IDLE.
- **BUSY**
  - While `cnt != 0`, decrement `cnt`.
  - When `cnt == 0`, the next edge performs the access and goes to RESP.
- **RESP**
  - Lasts exactly one cycle, then unconditionally returns to IDLE.
  - The pipeline advances on the edge that ends RESP. Any request seen in the following IDLE cycle is a new instruction.
- **`mem_stall`** is combinational: `(IDLE & (mem_ren|mem_wen)) | BUSY`. It is 0 in RESP.
- **Request stability:** the datapath holds the request stable while `mem_stall=1`. The responder uses only the copy captured on the IDLE→BUSY edge.
- **Error detection**, evaluated at capture:
  - Error if `addr[1:0] != 0` (misaligned).
  - Error if `addr[31:ADDR_WIDTH+2] != 0` (out of range).
  - Error if `mem_ren & mem_wen` (both asserted). In this case the access is still performed as a store, provided the address itself is legal.
- **Erroneous access:**
  - The array is not accessed when the address is misaligned or out of range.
  - `mem_din` is loaded with 0.
  - Full latency still applies; `mem_err=1` and `mem_ack=1` in RESP.
- **Legal store:**
  - On the BUSY→RESP edge, `array[addr[ADDR_WIDTH+1:2]] <= data`.
  - `mem_din` is unchanged.
- **Legal load:**
  - On the BUSY→RESP edge, `mem_din <= array[index]`.
  - `mem_din` holds that value until the next completed load or error.
- **Counters:**
  - `rd_count` increments on the BUSY→RESP edge of a non-error load.
  - `wr_count` increments on the same edge of any store actually written.
  - Both saturate at 0xFFFF.
- **Array contents:** not reset; they are undefined until written.

## Timing
- **Latency:** request first visible in IDLE at cycle T, with `mem_stall=1` from T.
  - BUSY occupies cycles T+1 .. T+LATENCY, with `mem_stall=1`.
  - RESP is at T+LATENCY+1, with `mem_ack=1`, `mem_stall=0` and load data valid.
  - The datapath is therefore frozen for LATENCY+1 cycles per access.
- **Throughput:** back-to-back accesses are one request per LATENCY+2 cycles, because every access passes through one IDLE cycle.
- **Output registers:** `mem_ack` and `mem_err` are registered and high only in RESP. `mem_din` is registered.
- **Reset values** (`rst_n=0`, asynchronous):
  - State IDLE, `cnt=0`.
  - `mem_din=0`, `mem_ack=0`, `mem_err=0`, `rd_count=0`, `wr_count=0`.
  - `mem_stall` follows its equation, so it is 0 unless a request is present.
- **Reset mid-access:** a pending store is discarded, because the write occurs only on the BUSY→RESP edge. The array location keeps its old value.
- **Reset release:** the first capture occurs on the first edge after release with a request present.

## Test plan
- **Reset:** drive `rst_n=0` mid-cycle with random inputs and no request -> every output reads 0 immediately, before the next clock edge.
- **Store then load:** with LATENCY=2, store 0xDEADBEEF to 0x10 at T -> `mem_stall` high for T..T+2, `mem_ack` at T+3, `wr_count=1`. Then load 0x10 -> `mem_din=0xDEADBEEF` in its RESP cycle, `rd_count=1`.
- **Misaligned load:** load from 0x13 -> `mem_ack=1`, `mem_err=1` at T+3, `mem_din=0`. `rd_count` is unchanged and the word at 0x10 is unchanged.
- **Out of range:** with ADDR_WIDTH=10, store 0x12345678 to 0x1000 -> `mem_err=1`, `wr_count` unchanged. A load from 0x0 still returns its prior value.
- **Both requests:** assert `mem_ren=mem_wen=1` at 0x20 with data 0xA5A5A5A5 -> `mem_err=1`, and a later load from 0x20 returns 0xA5A5A5A5.
- **Reset during store:** store 0x11111111 to 0x20, pulse `rst_n` low during BUSY -> `mem_stall=0`, no `mem_ack`. A later load from 0x20 returns 0xA5A5A5A5. Also check counter saturation: preset near 0xFFFF via 0xFFFF+2 stores -> `wr_count` stays at 0xFFFF.
